// File: rtl/plot_arbiter.sv
// plot_arbiter
//   Merges pixel streams from three renderers (left paddle, right paddle, ball)
//   into one VGA write port. Each source has its own small FIFO. Pixels outside
//   the screen are discarded on entry. One pixel per cycle is forwarded to the
//   output registers, and the sources are served in round-robin order.
//
// Ports
//   iClock                 rising-edge clock
//   iReset                 synchronous, active-high reset
//   iX0/iX1/iX2   [XW-1:0] pixel x from source 0/1/2
//   iY0/iY1/iY2   [YW-1:0] pixel y from source 0/1/2
//   iColour0..2   [2:0]    pixel colour from source 0/1/2
//   iPlot0..2              source presents a pixel this cycle (no back-pressure)
//   iNewFrame     [2:0]    per-source end-of-frame pulse
//   oX/oY/oColour          merged pixel (held while oPlot is low)
//   oPlot                  VGA write enable
//   oOverflow     [2:0]    sticky per-source "pixel dropped on full FIFO"
//   oFrameDone             one-cycle pulse: all sources finished and drained
//
// Handshake: iPlotn is a valid-only strobe. The arbiter never stalls a source.
// A pixel that arrives while its FIFO is full, and that FIFO is not being
// popped on the same edge, is lost and recorded in oOverflow.
module plot_arbiter #(
  parameter int X_SCREEN_PIXELS = 320,
  parameter int Y_SCREEN_PIXELS = 240,
  parameter int FIFO_DEPTH      = 4,
  localparam int XW = $clog2(X_SCREEN_PIXELS) + 1,
  localparam int YW = $clog2(Y_SCREEN_PIXELS) + 1
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic [XW-1:0] iX0,
  input  logic [XW-1:0] iX1,
  input  logic [XW-1:0] iX2,
  input  logic [YW-1:0] iY0,
  input  logic [YW-1:0] iY1,
  input  logic [YW-1:0] iY2,
  input  logic [2:0]    iColour0,
  input  logic [2:0]    iColour1,
  input  logic [2:0]    iColour2,
  input  logic          iPlot0,
  input  logic          iPlot1,
  input  logic          iPlot2,
  input  logic [2:0]    iNewFrame,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic [2:0]    oColour,
  output logic          oPlot,
  output logic [2:0]    oOverflow,
  output logic          oFrameDone
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = XW + YW + 3;

  // Per-source views of the flat input ports.
  logic [XW-1:0] in_x   [3];
  logic [YW-1:0] in_y   [3];
  logic [2:0]    in_col [3];
  logic [2:0]    in_plot;

  assign in_x[0]   = iX0;
  assign in_x[1]   = iX1;
  assign in_x[2]   = iX2;
  assign in_y[0]   = iY0;
  assign in_y[1]   = iY1;
  assign in_y[2]   = iY2;
  assign in_col[0] = iColour0;
  assign in_col[1] = iColour1;
  assign in_col[2] = iColour2;
  assign in_plot   = {iPlot2, iPlot1, iPlot0};

  // FIFO storage: entry = {x, y, colour}.
  logic [EW-1:0] mem    [3][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [3];
  logic [AW-1:0] rd_ptr [3];
  logic [CW-1:0] count  [3];

  logic [1:0] rr;
  logic [2:0] pending;

  logic [2:0]    not_empty;
  logic [2:0]    full;
  logic [2:0]    push_req;
  logic [2:0]    accept;
  logic [2:0]    pop;
  logic [2:0]    ovf_set;
  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic [EW-1:0] grant_entry;
  logic          frame_done_cond;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Occupancy flags and clipping. Flags come from registered counts only, so
  // a pixel pushed on this edge cannot be granted until the next one.
  always_comb begin
    not_empty = '0;
    full      = '0;
    push_req  = '0;
    for (int n = 0; n < 3; n++) begin
      not_empty[n] = (count[n] != '0);
      full[n]      = (count[n] == CW'(FIFO_DEPTH));
      push_req[n]  = in_plot[n] &&
                     (in_x[n] < XW'(X_SCREEN_PIXELS)) &&
                     (in_y[n] < YW'(Y_SCREEN_PIXELS));
    end
  end

  // Round-robin search starting at rr.
  always_comb begin
    logic [1:0] c1;
    logic [1:0] c2;
    c1          = inc3(rr);
    c2          = inc3(c1);
    grant_valid = 1'b1;
    grant_idx   = rr;
    if (not_empty[rr])      grant_idx = rr;
    else if (not_empty[c1]) grant_idx = c1;
    else if (not_empty[c2]) grant_idx = c2;
    else                    grant_valid = 1'b0;
  end

  assign pop         = grant_valid ? (3'b001 << grant_idx) : 3'b000;
  // A full FIFO still accepts when it is popped on the same edge.
  assign accept      = push_req & (~full | pop);
  assign ovf_set     = push_req & full & ~pop;
  assign grant_entry = mem[grant_idx][rd_ptr[grant_idx]];

  assign frame_done_cond = (pending == 3'b111) && (not_empty == 3'b000) &&
                           (accept == 3'b000);

  // Storage array: no reset needed, pointers/counts define validity.
  always_ff @(posedge iClock) begin
    for (int n = 0; n < 3; n++) begin
      if (accept[n]) mem[n][wr_ptr[n]] <= {in_x[n], in_y[n], in_col[n]};
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int n = 0; n < 3; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
      end
      rr         <= 2'd0;
      pending    <= 3'b000;
      oOverflow  <= 3'b000;
      oPlot      <= 1'b0;
      oFrameDone <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oColour    <= 3'b000;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (accept[n]) wr_ptr[n] <= wr_ptr[n] + AW'(1);
        if (pop[n])    rd_ptr[n] <= rd_ptr[n] + AW'(1);
        if (accept[n] && !pop[n])      count[n] <= count[n] + CW'(1);
        else if (!accept[n] && pop[n]) count[n] <= count[n] - CW'(1);
        if (ovf_set[n]) oOverflow[n] <= 1'b1;
      end

      oPlot <= grant_valid;
      if (grant_valid) begin
        rr      <= inc3(grant_idx);
        oX      <= grant_entry[EW-1 -: XW];
        oY      <= grant_entry[3 +: YW];
        oColour <= grant_entry[2:0];
      end

      // Clearing pending still keeps any end-of-frame pulse landing now.
      oFrameDone <= frame_done_cond;
      if (frame_done_cond) pending <= iNewFrame;
      else                 pending <= pending | iNewFrame;
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
module tb_plot_arbiter;

  localparam int XS = 320;
  localparam int YS = 240;
  localparam int D  = 4;

  logic       clk;
  logic       d_rst;
  logic [9:0] d_x [3];
  logic [8:0] d_y [3];
  logic [2:0] d_c [3];
  logic [2:0] d_plot;
  logic [2:0] d_nf;

  logic [9:0] oX;
  logic [8:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic [2:0] oOverflow;
  logic       oFrameDone;

  plot_arbiter dut (
    .iClock    (clk),
    .iReset    (d_rst),
    .iX0       (d_x[0]),
    .iX1       (d_x[1]),
    .iX2       (d_x[2]),
    .iY0       (d_y[0]),
    .iY1       (d_y[1]),
    .iY2       (d_y[2]),
    .iColour0  (d_c[0]),
    .iColour1  (d_c[1]),
    .iColour2  (d_c[2]),
    .iPlot0    (d_plot[0]),
    .iPlot1    (d_plot[1]),
    .iPlot2    (d_plot[2]),
    .iNewFrame (d_nf),
    .oX        (oX),
    .oY        (oY),
    .oColour   (oColour),
    .oPlot     (oPlot),
    .oOverflow (oOverflow),
    .oFrameDone(oFrameDone)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;

  // Pending pixels per source, packed {x, y, colour}.
  logic [21:0] exp_q0[$];
  logic [21:0] exp_q1[$];
  logic [21:0] exp_q2[$];
  int          m_rr;
  logic [2:0]  m_pend;
  logic [2:0]  m_ovf;
  logic [9:0]  m_x;
  logic [8:0]  m_y;
  logic [2:0]  m_c;
  logic        m_plot;
  logic        m_fd;

  function automatic int qsize(input int n);
    case (n)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [21:0] qpop(input int n);
    case (n)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic void qpush(input int n, input logic [21:0] v);
    case (n)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  // One clock edge of behaviour, from the block's rules.
  function automatic void model_edge();
    int          sz [3];
    int          g;
    bit          all_empty;
    bit          accepted;
    logic [21:0] e;
    if (d_rst) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      m_rr = 0; m_pend = '0; m_ovf = '0;
      m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0; m_fd = 1'b0;
      return;
    end
    for (int n = 0; n < 3; n++) sz[n] = qsize(n);
    all_empty = (sz[0] == 0) && (sz[1] == 0) && (sz[2] == 0);
    g = -1;
    for (int k = 0; k < 3; k++) begin
      if (g < 0 && sz[(m_rr + k) % 3] > 0) g = (m_rr + k) % 3;
    end
    if (g >= 0) begin
      e = qpop(g);
      m_x = e[21:12]; m_y = e[11:3]; m_c = e[2:0];
      m_plot = 1'b1;
      m_rr = (g + 1) % 3;
    end else begin
      m_plot = 1'b0;
    end
    accepted = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (d_plot[n] && d_x[n] < XS && d_y[n] < YS) begin
        if (qsize(n) < D) begin
          qpush(n, {d_x[n], d_y[n], d_c[n]});
          accepted = 1'b1;
        end else begin
          m_ovf[n] = 1'b1;
        end
      end
    end
    m_fd = (m_pend == 3'b111) && all_empty && !accepted;
    m_pend = m_fd ? d_nf : (m_pend | d_nf);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    d_rst  = 1'b0;
    d_plot = 3'b000;
    d_nf   = 3'b000;
    for (int n = 0; n < 3; n++) begin
      d_x[n] = '0; d_y[n] = '0; d_c[n] = '0;
    end
  endtask

  // Apply current inputs for one edge, then compare every output to the model.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model", {5'd0, oX, oY, oColour, oPlot, oOverflow, oFrameDone},
                   {5'd0, m_x, m_y, m_c, m_plot, m_ovf, m_fd});
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [2:0] plot;
    logic [9:0] x0, x1, x2;
    logic [8:0] y;
    logic [2:0] c;
    logic [2:0] nf;
    logic       exp_plot;
    logic [9:0] exp_x;
    logic [2:0] exp_ovf;
    logic       exp_fd;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int plots;

    // rst  plot    x0  x1   x2  y    c  nf   | plot x   ovf fd
    vecs[0]  = '{1'b1, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b0, 10'd0,  3'd0, 1'b0};
    // single pixel: visible one edge after the push, gone the edge after
    vecs[1]  = '{1'b0, 3'b001, 10'd10, 10'd0,   10'd0, 9'd100, 3'd7, 3'd0, 1'b0, 10'd0,  3'd0, 1'b0};
    vecs[2]  = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b1, 10'd10, 3'd0, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b0, 10'd10, 3'd0, 1'b0};
    // contention from rr=0: 1, 2, 3 on consecutive cycles
    vecs[4]  = '{1'b1, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b0, 10'd0,  3'd0, 1'b0};
    vecs[5]  = '{1'b0, 3'b111, 10'd1,  10'd2,   10'd3, 9'd9,   3'd2, 3'd0, 1'b0, 10'd0,  3'd0, 1'b0};
    vecs[6]  = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b1, 10'd1,  3'd0, 1'b0};
    vecs[7]  = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b1, 10'd2,  3'd0, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b1, 10'd3,  3'd0, 1'b0};
    vecs[9]  = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b0, 10'd3,  3'd0, 1'b0};
    // rr is back at 0: source 0 wins over source 1
    vecs[10] = '{1'b0, 3'b011, 10'd5,  10'd6,   10'd0, 9'd4,   3'd1, 3'd0, 1'b0, 10'd3,  3'd0, 1'b0};
    vecs[11] = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b1, 10'd5,  3'd0, 1'b0};
    vecs[12] = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b1, 10'd6,  3'd0, 1'b0};
    // clipping on x (=320) and on y (=240): never plotted, no overflow
    vecs[13] = '{1'b0, 3'b010, 10'd0,  10'd320, 10'd0, 9'd5,   3'd3, 3'd0, 1'b0, 10'd6,  3'd0, 1'b0};
    vecs[14] = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b0, 10'd6,  3'd0, 1'b0};
    vecs[15] = '{1'b0, 3'b100, 10'd0,  10'd0,   10'd3, 9'd240, 3'd3, 3'd0, 1'b0, 10'd6,  3'd0, 1'b0};
    vecs[16] = '{1'b0, 3'b000, 10'd0,  10'd0,   10'd0, 9'd0,   3'd0, 3'd0, 1'b0, 10'd6,  3'd0, 1'b0};

    set_idle();
    d_rst = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 17; i++) begin
      set_idle();
      d_rst  = vecs[i].rst;
      d_plot = vecs[i].plot;
      d_x[0] = vecs[i].x0; d_x[1] = vecs[i].x1; d_x[2] = vecs[i].x2;
      for (int n = 0; n < 3; n++) begin
        d_y[n] = vecs[i].y; d_c[n] = vecs[i].c;
      end
      d_nf = vecs[i].nf;
      tick();
      check($sformatf("vec%0d", i), {17'd0, oPlot, oX, oOverflow, oFrameDone},
            {17'd0, vecs[i].exp_plot, vecs[i].exp_x, vecs[i].exp_ovf, vecs[i].exp_fd});
    end

    // ---- overflow: three sources streaming, source 2 for 8 cycles ----
    set_idle(); d_rst = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      set_idle();
      d_plot = 3'b111;
      for (int n = 0; n < 3; n++) begin
        d_x[n] = 10'(n * 100 + i); d_y[n] = 9'(i); d_c[n] = 3'(n + 1);
      end
      tick();
    end
    set_idle();
    for (int i = 0; i < 15; i++) tick();
    check("ovf_src2_set", {31'd0, oOverflow[2]}, 32'd1);
    set_idle(); d_rst = 1'b1; tick();
    check("ovf_reset_clear", {29'd0, oOverflow}, 32'd0);

    // ---- frame done: end-of-frame pulses staggered while FIFO 1 is busy ----
    set_idle(); d_plot = 3'b010; d_x[1] = 10'd20; d_y[1] = 9'd50; d_nf = 3'b001; tick();
    set_idle(); d_plot = 3'b010; d_x[1] = 10'd21; d_y[1] = 9'd51; d_nf = 3'b010; tick();
    check("fd_pop1", {20'd0, oPlot, oX, oFrameDone}, {20'd0, 1'b1, 10'd20, 1'b0});
    set_idle(); d_nf = 3'b100; tick();
    check("fd_lastpop", {20'd0, oPlot, oX, oFrameDone}, {20'd0, 1'b1, 10'd21, 1'b0});
    set_idle(); tick();
    check("fd_pulse", {30'd0, oPlot, oFrameDone}, {30'd0, 1'b0, 1'b1});
    tick();
    check("fd_oneshot", {31'd0, oFrameDone}, 32'd0);

    // ---- reset mid-stream with three entries queued ----
    set_idle(); d_rst = 1'b1; tick();
    set_idle(); d_plot = 3'b111;
    d_x[0] = 10'd40; d_x[1] = 10'd41; d_x[2] = 10'd42;
    tick();
    set_idle(); d_rst = 1'b1; d_plot = 3'b111; d_nf = 3'b111; tick();
    check("rst_mid_plot", {31'd0, oPlot}, 32'd0);
    set_idle();
    plots = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (oPlot) plots++;
    end
    check("rst_no_stale", 32'(plots), 32'd0);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 2000; i++) begin
      set_idle();
      d_rst = ($urandom_range(0, 249) == 0);
      for (int n = 0; n < 3; n++) begin
        d_plot[n] = ($urandom_range(0, 2) == 0);
        d_x[n]    = 10'($urandom_range(0, 335));
        d_y[n]    = 9'($urandom_range(0, 250));
        d_c[n]    = 3'($urandom_range(0, 7));
        d_nf[n]   = ($urandom_range(0, 11) == 0);
      end
      tick();
    end
    set_idle();
    for (int i = 0; i < 20; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
